penal_scoreboard: RTL and testbench
===================================

// Module: penal_scoreboard
// PURPOSE
// - Display/scoring end of the penalty-game datapath: consumes the debounced kick strobe, the goal and
//   invalid-input flags, and the active penalty count / finish flag; keeps goal and save tallies.
// - Drives a 4-digit multiplexed 7-segment display (goals, saves, penalty number, mode).
// - Sits beside the game FSM and penalty counters at top level; it is a pure reader of their outputs.
// PARAMETERS
// - REFRESH_DIV  50000  clk cycles per digit-scan step (>=2)
// - BLINK_DIV    64     scan steps per blink half-period once the game is done (>=2)
// - MAX_PEN      5      saturation value for goal/save tallies
// PORTS
// - clk      in   1  system clock, rising edge
// - rst      in   1  asynchronous, active-high reset
// - en       in   1  global enable; when 0, all registers hold their value
// - clr      in   1  synchronous clear of tallies, done flag and blink phase (new game)
// - kick     in   1  one-cycle debounced kick pulse
// - goal     in   1  direction matches keeper miss (C); sampled only when kick=1
// - noT      in   1  invalid switch combination; a kick with noT=1 is ignored
// - cont     in   3  current penalty number (0..5) from the active counter
// - fin      in   1  active counter finished (level)
// - mode5    in   1  1 = 5-penalty mode, 0 = 3-penalty mode
// - seg      out  7  segments {g,f,e,d,c,b,a}, active-low
// - an       out  4  digit enables, active-low, one-hot-low
// - goals    out  3  goal tally
// - saves    out  3  save tally
// - done     out  1  game-over latch
// BEHAVIOUR
// - Reset: goals=0, saves=0, done=0, prescaler=0, scan index=0, blink phase=on, an=4'b1110,
//   seg=decode(0)=7'b1000000.
// - Tally (when en=1, clr=0, done=0): kick&~noT&goal -> goals+1; kick&~noT&~goal -> saves+1;
//   registered, visible the cycle after kick. A tally at MAX_PEN holds (saturating, no wrap).
// - done: set on the first cycle fin=1 (en=1); held until clr or rst. Kicks with done=1 are ignored,
//   including a kick in the same cycle fin first rises (done-set wins over tally).
// - clr has priority over kick and fin in the same cycle; it does not reset prescaler or scan index.
// - Prescaler counts 0..REFRESH_DIV-1 then wraps; the wrap cycle is a scan tick.
// - Scan index 2-bit, +1 per scan tick, wraps 3->0. an = ~(4'b0001 << index), registered with index.
// - Digit content: 0 -> goals, 1 -> saves, 2 -> cont, 3 -> 3'd5 if mode5 else 3'd3.
// - seg is combinational from scan index and current data (same-cycle update as tallies change).
// - Blink: while done=1, a counter of scan ticks toggles phase every BLINK_DIV ticks; in off phase
//   digits 2 and 3 show blank (seg=7'h7F, an unchanged); digits 0-1 always shown. done=0 -> phase on.
// - cont values 6..7 are illegal; display shows '-' (7'b0111111). No other checking.
// - en=0: every counter and register holds; seg/an keep showing the current digit.
// - rst mid-scan or mid-game returns all state to reset values asynchronously.
// STRUCTURE
// - Shared package/header: SEG_BLANK, SEG_DASH, SEG_DIGIT[0..9] constants (active-low gfedcba),
//   DIGIT_GOALS/SAVES/PEN/MODE index constants.
// - One sub-module: seg7_decoder (3-bit value + blank -> seg[6:0]), combinational.
// - Remaining logic (tallies, done latch, prescaler, scan, blink) flat in this module.
// TESTING  (REFRESH_DIV=4, BLINK_DIV=2)
// - Reset then run 16 cycles -> an steps 1110,1101,1011,0111 every 4 clk; seg=7'b1000000 on digits 0-2,
//   digit 3 shows '3' (7'b0110000) with mode5=0.
// - 3 kicks goal=1, 2 kicks goal=0, noT=0 -> goals=3, saves=2; each updates 1 cycle after kick.
// - Kick with noT=1 and goal=1 -> goals/saves unchanged.
// - 7 goal kicks -> goals saturates at 5, saves=0.
// - fin=1 with kick in same cycle -> done=1, tallies unchanged; later kicks ignored; digits 2-3
//   alternate blank/visible every 2 scan ticks while digits 0-1 stay lit.
// - clr=1 after done -> goals=saves=0, done=0, blinking stops; en=0 for 10 cycles -> an frozen.

Source files
------------

// File: rtl/penal_scoreboard_pkg.sv
// rtl/penal_scoreboard_pkg.sv - shared display constants for the penalty scoreboard
package penal_scoreboard_pkg;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    // active-low {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_DIGIT [10] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };

    localparam logic [1:0] DIGIT_GOALS = 2'd0;
    localparam logic [1:0] DIGIT_SAVES = 2'd1;
    localparam logic [1:0] DIGIT_PEN   = 2'd2;
    localparam logic [1:0] DIGIT_MODE  = 2'd3;

endpackage

// File: rtl/penal_scoreboard_seg7_decoder.sv
// rtl/penal_scoreboard_seg7_decoder.sv - 3-bit value to active-low 7-segment pattern
module seg7_decoder
    import penal_scoreboard_pkg::*;
(
    input  logic [2:0] value,
    input  logic       blank,
    output logic [6:0] seg
);

    // values above 5 never come from a legal source, so they render as a dash
    always_comb begin
        seg = SEG_DASH;
        if (blank)
            seg = SEG_BLANK;
        else if (value <= 3'd5)
            seg = SEG_DIGIT[{1'b0, value}];
    end

endmodule

// File: rtl/penal_scoreboard.sv
// rtl/penal_scoreboard.sv - goal/save tallies, game-over latch and multiplexed 7-segment scan
module penal_scoreboard
    import penal_scoreboard_pkg::*;
#(
    parameter int REFRESH_DIV = 50000,
    parameter int BLINK_DIV   = 64,
    parameter int MAX_PEN     = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       clr,
    input  logic       kick,
    input  logic       goal,
    input  logic       noT,
    input  logic [2:0] cont,
    input  logic       fin,
    input  logic       mode5,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic [2:0] goals,
    output logic [2:0] saves,
    output logic       done
);

    localparam int PW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam int BW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(REFRESH_DIV - 1);
    localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_DIV - 1);
    localparam logic [2:0]    TALLY_MAX = 3'(MAX_PEN);

    logic [PW-1:0] presc;
    logic [1:0]    idx;
    logic [BW-1:0] bcnt;
    logic          phase;
    logic          tick;
    logic          score;
    logic [2:0]    digit_val;

    assign tick  = en && (presc == PRESC_MAX);
    // a kick in the cycle fin rises is dropped: the done latch takes precedence
    assign score = kick && !noT && !done && !fin;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc <= '0;
            idx   <= 2'd0;
        end else if (en) begin
            presc <= tick ? '0 : presc + 1'b1;
            if (tick)
                idx <= idx + 2'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            goals <= 3'd0;
            saves <= 3'd0;
            done  <= 1'b0;
        end else if (en) begin
            if (clr) begin
                goals <= 3'd0;
                saves <= 3'd0;
                done  <= 1'b0;
            end else begin
                if (fin)
                    done <= 1'b1;
                if (score && goal && goals < TALLY_MAX)
                    goals <= goals + 3'd1;
                if (score && !goal && saves < TALLY_MAX)
                    saves <= saves + 3'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bcnt  <= '0;
            phase <= 1'b1;
        end else if (en) begin
            if (clr || !done) begin
                bcnt  <= '0;
                phase <= 1'b1;
            end else if (tick) begin
                if (bcnt == BLINK_MAX) begin
                    bcnt  <= '0;
                    phase <= ~phase;
                end else begin
                    bcnt <= bcnt + 1'b1;
                end
            end
        end
    end

    assign an = ~(4'b0001 << idx);

    always_comb begin
        digit_val = goals;
        case (idx)
            DIGIT_GOALS: digit_val = goals;
            DIGIT_SAVES: digit_val = saves;
            DIGIT_PEN:   digit_val = cont;
            DIGIT_MODE:  digit_val = mode5 ? 3'd5 : 3'd3;
            default:     digit_val = goals;
        endcase
    end

    seg7_decoder u_dec (
        .value (digit_val),
        .blank (!phase && idx[1]),
        .seg   (seg)
    );

endmodule

// File: tb/tb_penal_scoreboard.sv
// tb/tb_penal_scoreboard.sv - directed self-checking bench for penal_scoreboard
module tb_penal_scoreboard;

    logic       clk = 1'b0;
    logic       rst, en, clr, kick, goal, noT, fin, mode5;
    logic [2:0] cont;
    logic [6:0] seg;
    logic [3:0] an;
    logic [2:0] goals, saves;
    logic       done;

    int checks = 0;
    int errors = 0;

    // reference state for the scan/blink timing (REFRESH_DIV=4, BLINK_DIV=2)
    int m_p, m_idx, m_b, m_ph, m_done;
    int exp_goals, exp_saves;
    logic [3:0] an_hold;

    penal_scoreboard #(.REFRESH_DIV(4), .BLINK_DIV(2), .MAX_PEN(5)) dut (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .kick(kick), .goal(goal), .noT(noT),
        .cont(cont), .fin(fin), .mode5(mode5), .seg(seg), .an(an), .goals(goals),
        .saves(saves), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] exp_seg(input int idx, input int g, input int s, input int c,
                                           input logic m5, input int ph);
        logic [6:0] tbl [8];
        int v;
        tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h3F, 7'h3F};
        if (idx >= 2 && ph == 0) return 7'h7F;
        case (idx)
            0:       v = g;
            1:       v = s;
            2:       v = c;
            default: v = m5 ? 5 : 3;
        endcase
        return tbl[v];
    endfunction

    task automatic model_reset();
        m_p = 0; m_idx = 0; m_b = 0; m_ph = 1; m_done = 0;
        exp_goals = 0; exp_saves = 0;
    endtask

    task automatic step();
        bit t;
        t = en && (m_p == 3);
        if (en) begin
            m_p = (m_p + 1) % 4;
            if (t) m_idx = (m_idx + 1) % 4;
            if (clr) begin
                m_done = 0; m_ph = 1; m_b = 0;
            end else begin
                if (!m_done) begin
                    m_b = 0; m_ph = 1;
                end else if (t) begin
                    if (m_b == 1) begin m_b = 0; m_ph = 1 - m_ph; end
                    else m_b = m_b + 1;
                end
                if (fin) m_done = 1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_disp();
        logic [3:0] ea;
        ea = ~(4'b0001 << m_idx);
        chk("an", {28'd0, an}, {28'd0, ea});
        chk("seg", {25'd0, seg}, {25'd0, exp_seg(m_idx, exp_goals, exp_saves, int'(cont), mode5, m_ph)});
        chk("done", {31'd0, done}, m_done);
    endtask

    task automatic tally_chk(input string tag);
        chk({tag, "_goals"}, {29'd0, goals}, exp_goals);
        chk({tag, "_saves"}, {29'd0, saves}, exp_saves);
    endtask

    task automatic do_kick(input logic g, input logic nt);
        kick = 1'b1; goal = g; noT = nt;
        tally_chk("pre_kick");
        if (!nt && !m_done && !fin) begin
            if (g && exp_goals < 5) exp_goals++;
            if (!g && exp_saves < 5) exp_saves++;
        end
        step();
        kick = 1'b0; goal = 1'b0; noT = 1'b0;
        tally_chk("post_kick");
        check_disp();
    endtask

    initial begin
        logic [4:0] pat;
        rst = 1'b1; en = 1'b1; clr = 1'b0; kick = 1'b0; goal = 1'b0; noT = 1'b0;
        fin = 1'b0; mode5 = 1'b0; cont = 3'd0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_an", {28'd0, an}, 32'h0000000E);
        chk("rst_seg", {25'd0, seg}, 32'h00000040);
        tally_chk("rst");
        chk("rst_done", {31'd0, done}, 0);

        for (int i = 0; i < 16; i++) begin
            step();
            check_disp();
        end
        chk("scan_wrap_an", {28'd0, an}, 32'h0000000E);

        pat = 5'b00111;
        for (int i = 0; i < 5; i++) do_kick(pat[i], 1'b0);
        chk("tally_goals3", {29'd0, goals}, 3);
        chk("tally_saves2", {29'd0, saves}, 2);

        do_kick(1'b1, 1'b1);

        cont = 3'd7;
        for (int i = 0; i < 16; i++) begin step(); check_disp(); end
        cont = 3'd2; mode5 = 1'b1;
        for (int i = 0; i < 16; i++) begin step(); check_disp(); end

        clr = 1'b1; exp_goals = 0; exp_saves = 0;
        step();
        clr = 1'b0;
        tally_chk("clr1");

        for (int i = 0; i < 7; i++) do_kick(1'b1, 1'b0);
        chk("sat_goals", {29'd0, goals}, 5);
        chk("sat_saves", {29'd0, saves}, 0);

        fin = 1'b1;
        do_kick(1'b0, 1'b0);
        chk("fin_done", {31'd0, done}, 1);
        do_kick(1'b0, 1'b0);
        fin = 1'b0;
        do_kick(1'b1, 1'b0);
        for (int i = 0; i < 40; i++) begin step(); check_disp(); end

        clr = 1'b1; exp_goals = 0; exp_saves = 0;
        step();
        clr = 1'b0;
        tally_chk("clr2");
        chk("clr_done", {31'd0, done}, 0);
        for (int i = 0; i < 16; i++) begin step(); check_disp(); end

        an_hold = an;
        en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("en0_an", {28'd0, an}, {28'd0, an_hold});
            check_disp();
        end
        en = 1'b1;
        for (int i = 0; i < 8; i++) begin step(); check_disp(); end

        do_kick(1'b1, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        chk("arst_an", {28'd0, an}, 32'h0000000E);
        chk("arst_goals", {29'd0, goals}, 0);
        chk("arst_done", {31'd0, done}, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin step(); check_disp(); end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
